// File: rtl/mf_clk_pkg.sv
// Shared constants and helpers for the master-clock enable generator.
// Divider defaults, lock qualification length and the master clock rate.
package mf_clk_pkg;

  localparam int unsigned LOCK_CYCLES_DEF = 1024;
  localparam int unsigned DIV_H40_DEF     = 8;
  localparam int unsigned DIV_H32_DEF     = 10;
  localparam int unsigned DIV_68K_DEF     = 7;
  localparam int unsigned DIV_Z80_DEF     = 15;
  localparam int unsigned DIV_Q_DEF       = 4;

  localparam int unsigned MASTER_HZ = 53_693_160;

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mf_clken_gen_if.sv
// Control and enable bundle between the enable generator and the core.
// The generator side is the master; the core side is the slave.
interface mf_clken_gen_if;

  logic pll_locked;
  logic h40;
  logic ready;
  logic sys_rst;
  logic ce_pix;
  logic ce_pix_n;
  logic ce_68k;
  logic ce_z80;
  logic ce_q;
  logic lock_lost;

  modport master (
    input  pll_locked,
    input  h40,
    output ready,
    output sys_rst,
    output ce_pix,
    output ce_pix_n,
    output ce_68k,
    output ce_z80,
    output ce_q,
    output lock_lost
  );

  modport slave (
    output pll_locked,
    output h40,
    input  ready,
    input  sys_rst,
    input  ce_pix,
    input  ce_pix_n,
    input  ce_68k,
    input  ce_z80,
    input  ce_q,
    input  lock_lost
  );

endinterface

// File: rtl/mf_ce_div.sv
// Runtime-programmable clock-enable divider with a half-period companion pulse.
// The divide ratio is captured only at wrap, so a change never distorts the current period.
module mf_ce_div #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         ce,
  output logic         ce_half
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic [W-1:0] half;
  logic         wrap;

  always_comb begin
    wrap  = (cnt_q == div_q - 1'b1);
    half  = (div_q >> 1) - 1'b1;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    div_d = div_q;
    if (!en) begin
      // Track the requested ratio while idle so the first period already uses it.
      cnt_d = '0;
      div_d = div;
    end else if (wrap) begin
      div_d = div;
    end
    ce      = en & wrap;
    ce_half = en & (cnt_q == half);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= div;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/mf_clken_gen.sv
// Lock-qualified reset and single-cycle clock enables derived from the PLL master clock.
// All enables are gated by ready, so a lock drop suppresses any enable on that cycle.
module mf_clken_gen
  import mf_clk_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int unsigned DIV_H40     = DIV_H40_DEF,
  parameter int unsigned DIV_H32     = DIV_H32_DEF,
  parameter int unsigned DIV_68K     = DIV_68K_DEF,
  parameter int unsigned DIV_Z80     = DIV_Z80_DEF,
  parameter int unsigned DIV_Q       = DIV_Q_DEF
) (
  input logic            clk,
  input logic            rst,
  mf_clken_gen_if.master bus
);

  localparam int unsigned DIV_MAX =
      max_u(max_u(DIV_H40, DIV_H32), max_u(max_u(DIV_68K, DIV_Z80), DIV_Q));
  localparam int unsigned DIV_W = cnt_width(DIV_MAX + 1);
  localparam int unsigned QW    = cnt_width(LOCK_CYCLES + 1);
  localparam logic [QW-1:0] QMAX = QW'(LOCK_CYCLES);

  logic          sync1_q, lk_s_q;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic          ready_q, ready_d;
  logic          sys_rst_q;
  logic          lock_lost_q, lock_lost_d;

  always_comb begin
    qcnt_d      = '0;
    ready_d     = 1'b0;
    lock_lost_d = lock_lost_q | (ready_q & ~lk_s_q);
    if (lk_s_q) begin
      qcnt_d  = (qcnt_q == QMAX) ? QMAX : qcnt_q + 1'b1;
      ready_d = (qcnt_d == QMAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      lk_s_q      <= 1'b0;
      qcnt_q      <= '0;
      ready_q     <= 1'b0;
      sys_rst_q   <= 1'b1;
      lock_lost_q <= 1'b0;
    end else begin
      sync1_q     <= bus.pll_locked;
      lk_s_q      <= sync1_q;
      qcnt_q      <= qcnt_d;
      ready_q     <= ready_d;
      sys_rst_q   <= ~ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  logic [DIV_W-1:0] pix_div;
  logic             ce_pix, ce_pix_n, ce_68k, ce_z80, ce_q;
  logic             half_68k_unused, half_z80_unused, half_q_unused;

  assign pix_div = bus.h40 ? DIV_W'(DIV_H40) : DIV_W'(DIV_H32);

  mf_ce_div #(.W(DIV_W)) u_div_pix (
    .clk     (clk),
    .rst     (rst),
    .en      (ready_q),
    .div     (pix_div),
    .ce      (ce_pix),
    .ce_half (ce_pix_n)
  );

  mf_ce_div #(.W(DIV_W)) u_div_68k (
    .clk     (clk),
    .rst     (rst),
    .en      (ready_q),
    .div     (DIV_W'(DIV_68K)),
    .ce      (ce_68k),
    .ce_half (half_68k_unused)
  );

  mf_ce_div #(.W(DIV_W)) u_div_z80 (
    .clk     (clk),
    .rst     (rst),
    .en      (ready_q),
    .div     (DIV_W'(DIV_Z80)),
    .ce      (ce_z80),
    .ce_half (half_z80_unused)
  );

  mf_ce_div #(.W(DIV_W)) u_div_q (
    .clk     (clk),
    .rst     (rst),
    .en      (ready_q),
    .div     (DIV_W'(DIV_Q)),
    .ce      (ce_q),
    .ce_half (half_q_unused)
  );

  assign bus.ready     = ready_q;
  assign bus.sys_rst   = sys_rst_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.ce_pix    = ce_pix;
  assign bus.ce_pix_n  = ce_pix_n;
  assign bus.ce_68k    = ce_68k;
  assign bus.ce_z80    = ce_z80;
  assign bus.ce_q      = ce_q;

endmodule

// File: tb/tb_mf_clken_gen.sv
// Bench for mf_clken_gen: lock qualification, enable periods and phases, mode switching,
// lock loss and mid-run reset, with a ce_pix schedule scoreboard running throughout.
module tb_mf_clken_gen;
  import mf_clk_pkg::*;

  localparam int LC = int'(LOCK_CYCLES_DEF);

  logic clk = 1'b0;
  logic rst = 1'b1;

  mf_clken_gen_if bus ();

  mf_clken_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Bit order: 0 pix, 1 pix_n, 2 68k, 3 z80, 4 q.
  function automatic logic [4:0] ce_vec();
    return {bus.ce_q, bus.ce_z80, bus.ce_68k, bus.ce_pix_n, bus.ce_pix};
  endfunction

  // Scoreboard: each ce_pix (or ready rise) pushes the cycle of the next expected ce_pix,
  // using the h40 value seen on that cycle.
  int         exp_q[$];
  int         sb_pops    = 0;
  logic       ready_prev = 1'b0;
  logic       wide_seen  = 1'b0;
  logic       gate_bad   = 1'b0;
  logic [4:0] ce_prev    = '0;

  always @(negedge clk) begin
    logic [4:0] v;
    int         e;
    v = ce_vec();
    if ((v & ce_prev) != 5'd0) wide_seen <= 1'b1;
    if (!bus.ready && v != 5'd0) gate_bad <= 1'b1;
    ce_prev <= v;
    if (!bus.ready) begin
      exp_q.delete();
    end else begin
      if (!ready_prev) exp_q.push_back(cyc + (bus.h40 ? 7 : 9));
      if (bus.ce_pix) begin
        if (exp_q.size() == 0) begin
          check("pix_sched_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          sb_pops <= sb_pops + 1;
          check("pix_sched", cyc, e);
        end
        exp_q.push_back(cyc + (bus.h40 ? 8 : 10));
      end
    end
    ready_prev <= bus.ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input int sel, output int t);
    logic [4:0] v;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      v = ce_vec();
      if (v[sel]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check($sformatf("timeout_sel%0d", sel), 0, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, int'(bus.ready), 0);
    check({tag, "_sys_rst"}, int'(bus.sys_rst), 1);
    check({tag, "_ce"}, int'(ce_vec()), 0);
    check({tag, "_lock_lost"}, int'(bus.lock_lost), 0);
  endtask

  // Call right after driving pll_locked high: ready must rise on exactly the 2+LC-th edge.
  task automatic qualify(input string tag);
    logic early;
    early = 1'b0;
    for (int i = 0; i < LC + 1; i++) begin
      tick();
      if (bus.ready) early = 1'b1;
    end
    check({tag, "_early"}, int'(early), 0);
    tick();
    check({tag, "_ready"}, int'(bus.ready), 1);
    check({tag, "_sys_rst"}, int'(bus.sys_rst), 0);
  endtask

  // Call on the cycle ready rose: first pulse offsets in edges after that rise, h40=1.
  task automatic first_ce(input string tag);
    int         base;
    int         first[5];
    int         exp_first[5];
    logic [4:0] v;
    exp_first = '{7, 3, 6, 14, 3};
    first     = '{-1, -1, -1, -1, -1};
    base      = cyc;
    for (int i = 0; i < 16; i++) begin
      tick();
      v = ce_vec();
      for (int s = 0; s < 5; s++) if (v[s] && first[s] < 0) first[s] = cyc - base;
    end
    for (int s = 0; s < 5; s++) check($sformatf("%s_first%0d", tag, s), first[s], exp_first[s]);
  endtask

  typedef struct {
    string name;
    logic  h40;
    int    sel;
    int    period;
    int    half;
    int    hz;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t, t1, t2, t3, th, p, last, bad, nper;

    tbl[0] = '{"pix_h40", 1'b1, 0, 8,  4,  6_711_645};
    tbl[1] = '{"pix_h32", 1'b0, 0, 10, 5,  5_369_316};
    tbl[2] = '{"ce_68k",  1'b1, 2, 7,  -1, 7_670_451};
    tbl[3] = '{"ce_z80",  1'b1, 3, 15, -1, 3_579_544};
    tbl[4] = '{"ce_q",    1'b1, 4, 4,  -1, 13_423_290};

    bus.pll_locked = 1'b0;
    bus.h40        = 1'b1;
    rst            = 1'b1;
    tick();
    tick();
    check_reset("rst");

    // One-cycle glitch at qcnt=500 restarts qualification.
    rst            = 1'b0;
    bus.pll_locked = 1'b1;
    for (int i = 0; i < 502; i++) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    qualify("glitch");
    check("glitch_lock_lost", int'(bus.lock_lost), 0);
    first_ce("start");

    foreach (tbl[i]) begin
      bus.h40 = tbl[i].h40;
      if (tbl[i].sel == 0) begin
        wait_for(0, t);
        wait_for(0, t);
      end
      wait_for(tbl[i].sel, t1);
      if (tbl[i].half >= 0) begin
        wait_for(1, th);
        check({tbl[i].name, "_half"}, th - t1, tbl[i].half);
      end
      wait_for(tbl[i].sel, t2);
      check({tbl[i].name, "_period"}, t2 - t1, tbl[i].period);
      p = (t2 - t1 > 0) ? t2 - t1 : 1;
      check({tbl[i].name, "_hz"}, int'(MASTER_HZ) / p, tbl[i].hz);
    end

    // h40 1->0 at pixel counter 2: current period stays 8, the next is 10.
    bus.h40 = 1'b1;
    wait_for(0, t);
    wait_for(0, t);
    wait_for(0, t1);
    tick();
    tick();
    tick();
    bus.h40 = 1'b0;
    wait_for(0, t2);
    check("switch_cur_period", t2 - t1, 8);
    wait_for(0, t3);
    check("switch_next_period", t3 - t2, 10);

    last = -1;
    bad  = 0;
    nper = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.ce_pix) begin
        if (last >= 0 && cyc - last != 8 && cyc - last != 10) bad++;
        last = cyc;
        nper++;
      end
      bus.h40 = 1'($urandom_range(0, 1));
    end
    check("rand_bad_periods", bad, 0);
    check("rand_enough_periods", int'(nper >= 25), 1);

    // Lock loss after ready: drops within 3 edges, lock_lost is sticky across relock.
    bus.h40 = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.pll_locked = 1'b0;
    tick();
    tick();
    check("loss_ready_hold", int'(bus.ready), 1);
    tick();
    check("loss_ready", int'(bus.ready), 0);
    check("loss_sys_rst", int'(bus.sys_rst), 1);
    check("loss_lock_lost", int'(bus.lock_lost), 1);
    check("loss_ce", int'(ce_vec()), 0);
    for (int i = 0; i < 5; i++) tick();
    bus.pll_locked = 1'b1;
    qualify("relock");
    check("relock_lock_lost", int'(bus.lock_lost), 1);
    first_ce("relock");

    // Mid-run reset clears everything including lock_lost.
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    qualify("requal");
    first_ce("requal");

    check("ce_width", int'(wide_seen), 0);
    check("ce_gate", int'(gate_bad), 0);
    check("sb_pops", int'(sb_pops >= 20), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
